// File: rtl/trigger_record_framer_if.sv
// Readout stream of the trigger record framer: header plus record samples
// moved with a valid/ready handshake.
interface trigger_record_framer_if;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;

  modport master (output dout, output dout_valid, output dout_last, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/trigger_record_framer.sv
// Captures a fixed-length record around an accepted CFD trigger from a circular
// pretrigger history and streams it out behind a 32-bit timestamp header.
module trigger_record_framer #(
  parameter int unsigned PRETRIG    = 64,
  parameter int unsigned RECORD_LEN = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [15:0]                    x,
  input  logic                           trigger,
  trigger_record_framer_if.master        stream,
  output logic                           busy,
  output logic [15:0]                    trig_missed
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NWORDS = RECORD_LEN + 2;
  localparam int unsigned FILL_W = $clog2(PRETRIG + 1);
  localparam int unsigned POST_W = $clog2(RECORD_LEN);
  localparam int unsigned WIDX_W = $clog2(NWORDS + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PRETRIG);
  localparam logic [POST_W-1:0] POST_INIT = POST_W'(RECORD_LEN - PRETRIG - 1);
  localparam logic [WIDX_W-1:0] WIDX_END  = WIDX_W'(NWORDS);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NWORDS - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);

  typedef enum logic [1:0] {FILL, ARMED, CAPTURE, READOUT} state_t;

  state_t              state, state_next;
  logic [31:0]         ts, ts_trig;
  logic [ADDR_W-1:0]   wptr, raddr, rd_addr;
  logic [FILL_W-1:0]   fill_cnt;
  logic [POST_W-1:0]   post_cnt;
  logic [WIDX_W-1:0]   word_idx;
  logic [15:0]         mem [DEPTH];
  logic [15:0]         rdata;
  logic                we, accept, miss, load, xfer, last_xfer;

  always_comb begin
    xfer      = stream.dout_valid && stream.dout_ready;
    last_xfer = xfer && stream.dout_last;
    accept    = (state == ARMED) && enable && trigger;
    miss      = enable && trigger && (state != ARMED);
    we        = enable && (state != READOUT);
    load      = (state == READOUT) && (word_idx != WIDX_END) &&
                (!stream.dout_valid || stream.dout_ready);
    // raddr always names the next sample to load and rdata already holds it,
    // so the address moves one ahead in the same cycle a sample is consumed.
    rd_addr   = (load && (word_idx >= WIDX_W'(2))) ? raddr + 1'b1 : raddr;
    busy      = (state == CAPTURE) || (state == READOUT);

    state_next = state;
    unique case (state)
      FILL:    if (fill_cnt == FILL_FULL) state_next = ARMED;
      ARMED:   if (accept) state_next = (POST_INIT == '0) ? READOUT : CAPTURE;
      CAPTURE: if (enable && (post_cnt == POST_W'(1))) state_next = READOUT;
      READOUT: if (last_xfer) state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= FILL;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= x;
    rdata <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts                <= '0;
      ts_trig           <= '0;
      wptr              <= '0;
      raddr             <= '0;
      fill_cnt          <= '0;
      post_cnt          <= '0;
      word_idx          <= '0;
      trig_missed       <= '0;
      stream.dout       <= '0;
      stream.dout_valid <= 1'b0;
      stream.dout_last  <= 1'b0;
    end else begin
      if (enable) ts <= ts + 1'b1;
      if (we) wptr <= wptr + 1'b1;
      if (miss && (trig_missed != '1)) trig_missed <= trig_missed + 1'b1;

      if (last_xfer)
        fill_cnt <= '0;
      else if ((state == FILL) && enable && (fill_cnt != FILL_FULL))
        fill_cnt <= fill_cnt + 1'b1;

      if (accept) begin
        ts_trig  <= ts;
        raddr    <= wptr - PRE_OFS;
        post_cnt <= POST_INIT;
        word_idx <= '0;
      end else if ((state == CAPTURE) && enable) begin
        post_cnt <= post_cnt - 1'b1;
      end

      if (load) begin
        unique case (word_idx)
          WIDX_W'(0): stream.dout <= ts_trig[31:16];
          WIDX_W'(1): stream.dout <= ts_trig[15:0];
          default: begin
            stream.dout <= rdata;
            raddr       <= raddr + 1'b1;
          end
        endcase
        stream.dout_valid <= 1'b1;
        stream.dout_last  <= (word_idx == WIDX_LAST);
        word_idx          <= word_idx + 1'b1;
      end else if (xfer) begin
        stream.dout_valid <= 1'b0;
        stream.dout_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trigger_record_framer.sv
// Directed bench for trigger_record_framer: ramp samples, table of trigger
// scenarios, plus a mid-readout reset sequence.
module tb_trigger_record_framer;
  localparam int unsigned PRETRIG    = 8;
  localparam int unsigned RECORD_LEN = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned NWORDS     = RECORD_LEN + 2;
  localparam int unsigned NVEC       = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] x = '0;
  logic        busy;
  logic [15:0] trig_missed;

  trigger_record_framer_if bus ();

  trigger_record_framer #(
    .PRETRIG(PRETRIG),
    .RECORD_LEN(RECORD_LEN),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .x(x),
    .trigger(trigger),
    .stream(bus.master),
    .busy(busy),
    .trig_missed(trig_missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned trig [6];
    int unsigned ntrig;
    int unsigned nrec;
    int unsigned acc [2];
    int unsigned missed;
    bit          en_tog;
    bit          rdy_rand;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned ts_m;
  int unsigned trig_q [$];
  int unsigned acc_q [$];
  logic [16:0] got [$];
  int unsigned n_last;
  bit          en_tog, rdy_rand, phase;
  bit          hold_pending, chk_hi, chk_lo;
  logic [16:0] hold_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable = 1'b0;
    trigger = 1'b0;
    bus.dout_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_last", bus.dout_last, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_busy", busy, 0);
    check("rst_missed", trig_missed, 0);
    reset_n = 1'b1;
    ts_m = 0;
    got.delete();
    n_last = 0;
    hold_pending = 1'b0;
    chk_hi = 1'b0;
    chk_lo = 1'b0;
    phase = 1'b0;
  endtask

  // One clock: check held outputs, drive next inputs, log the transfer the
  // coming edge will perform, advance the bench timestamp.
  task automatic cycle();
    @(negedge clk);
    if (chk_hi) begin check("busy_rise", busy, 1); chk_hi = 1'b0; end
    if (chk_lo) begin check("busy_fall", busy, 0); chk_lo = 1'b0; end
    if (hold_pending) begin
      check("hold_valid", bus.dout_valid, 1);
      check("hold_word", {bus.dout_last, bus.dout}, hold_word);
    end
    phase = en_tog ? ~phase : 1'b1;
    enable = phase;
    x = ts_m[15:0];
    trigger = 1'b0;
    foreach (trig_q[i]) if (trig_q[i] == ts_m) trigger = 1'b1;
    bus.dout_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    hold_pending = bus.dout_valid && !bus.dout_ready;
    hold_word = {bus.dout_last, bus.dout};
    if (bus.dout_valid && bus.dout_ready) begin
      got.push_back({bus.dout_last, bus.dout});
      if (bus.dout_last) begin
        n_last++;
        check("busy_at_last", busy, 1);
        chk_lo = 1'b1;
      end
    end
    if ((acc_q.size() > 0) && enable && trigger && (ts_m == acc_q[0])) begin
      check("busy_at_accept", busy, 0);
      chk_hi = 1'b1;
      void'(acc_q.pop_front());
    end
    if (enable) ts_m++;
  endtask

  task automatic run_rec(input int unsigned nrec);
    int unsigned budget = 0;
    while ((n_last < nrec) && (budget < 3000)) begin
      cycle();
      budget++;
    end
    check("record_count", n_last, nrec);
    cycle();
    cycle();
  endtask

  task automatic verify(input int unsigned nrec, input int unsigned a0, input int unsigned a1);
    int unsigned a, base, lastpos, nl, idx;
    bit          found;
    logic [16:0] w;
    logic [15:0] e;
    check("word_count", got.size(), nrec * NWORDS);
    if (got.size() != nrec * NWORDS) return;
    for (int unsigned r = 0; r < nrec; r++) begin
      a = (r == 0) ? a0 : a1;
      base = r * NWORDS;
      w = got[base];
      check("hdr_hi", w[15:0], a >> 16);
      w = got[base + 1];
      check("hdr_lo", w[15:0], a & 32'h0000_FFFF);
      found = 1'b0;
      idx = RECORD_LEN - 1;
      for (int unsigned i = 0; i < RECORD_LEN; i++) begin
        w = got[base + 2 + i];
        e = 16'(a - PRETRIG + i);
        if (!found && (w[15:0] !== e)) begin
          found = 1'b1;
          idx = i;
        end
      end
      w = got[base + 2 + idx];
      check("sample", w[15:0], 16'(a - PRETRIG + idx));
      nl = 0;
      lastpos = NWORDS;
      for (int unsigned i = 0; i < NWORDS; i++) begin
        w = got[base + i];
        if (w[16]) begin
          nl++;
          if (lastpos == NWORDS) lastpos = i;
        end
      end
      check("last_pos", lastpos, NWORDS - 1);
      check("last_count", nl, 1);
    end
  endtask

  initial begin
    vec_t v [NVEC];
    int unsigned budget;
    // start 28 wraps the buffer end
    v[0] = '{'{100, 0, 0, 0, 0, 0}, 1, 1, '{100, 0}, 0, 1'b0, 1'b0};
    // fill incomplete at 5, reaching PRETRIG at 8, accept at 9
    v[1] = '{'{5, 8, 9, 0, 0, 0}, 3, 1, '{9, 0}, 2, 1'b0, 1'b0};
    // triggers in CAPTURE/READOUT, rejection one sample early in FILL, then accept
    v[2] = '{'{100, 105, 124, 130, 167, 168}, 6, 2, '{100, 168}, 4, 1'b0, 1'b0};
    // enable toggling and sparse ready
    v[3] = '{'{100, 0, 0, 0, 0, 0}, 1, 1, '{100, 0}, 0, 1'b1, 1'b1};
    v[4] = '{'{70, 0, 0, 0, 0, 0}, 1, 1, '{70, 0}, 0, 1'b0, 1'b0};

    bus.dout_ready = 1'b0;
    for (int unsigned k = 0; k < NVEC; k++) begin
      do_reset();
      en_tog = v[k].en_tog;
      rdy_rand = v[k].rdy_rand;
      trig_q.delete();
      acc_q.delete();
      for (int unsigned i = 0; i < v[k].ntrig; i++) trig_q.push_back(v[k].trig[i]);
      for (int unsigned i = 0; i < v[k].nrec; i++) acc_q.push_back(v[k].acc[i]);
      run_rec(v[k].nrec);
      verify(v[k].nrec, v[k].acc[0], v[k].acc[1]);
      check("trig_missed", trig_missed, v[k].missed);
    end

    // reset after the tenth transferred word aborts the record
    do_reset();
    en_tog = 1'b0;
    rdy_rand = 1'b0;
    trig_q = '{5, 100, 110};
    acc_q = '{100};
    budget = 0;
    while ((got.size() < 10) && (budget < 500)) begin
      cycle();
      budget++;
    end
    check("pre_reset_words", got.size(), 10);
    check("pre_reset_last", n_last, 0);
    check("pre_reset_missed", trig_missed, 2);
    do_reset();
    trig_q = '{20};
    acc_q = '{20};
    run_rec(1);
    verify(1, 20, 0);
    check("post_reset_missed", trig_missed, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/trigger_record_framer.md
# trigger_record_framer

Consumes the 16-bit filtered sample stream and the single-cycle `trigger` produced by the IIR/moving-mean CFD stage. It keeps a circular pretrigger history and, on an accepted trigger, captures one fixed-length record around the trigger sample. It then streams the record out, preceded by a timestamp header, over a valid/ready interface to the readout path. This block is the readout-side consumer of the CFD trigger.

## Interface
- `PRETRIG`, 64: samples preceding the trigger sample included in the record. Must satisfy 1 ≤ PRETRIG < RECORD_LEN.
- `RECORD_LEN`, 256: total samples per record. Must satisfy RECORD_LEN ≤ 2^ADDR_W.
- `ADDR_W`, 8: circular buffer address width. Depth is 2^ADDR_W words × 16 bits.

- `clk` in 1: sample clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: sample strobe. `x` and `trigger` are valid only when `enable`=1.
- `x` in 16: signed filtered sample.
- `trigger` in 1: CFD trigger, sampled only with `enable`.
- `dout` out 16: stream word.
- `dout_valid` out 1: `dout` is valid.
- `dout_ready` in 1: downstream accepts the word.
- `dout_last` out 1: marks the final word of a record.
- `busy` out 1: high in CAPTURE or READOUT.
- `trig_missed` out 16: count of triggers not accepted. Saturating.

## Operation
- Free-running 32-bit `ts` counter increments on every `enable` cycle and wraps. `ts` is 0 after reset.
- Sample index: the sample presented with `enable`=1 in a given cycle takes the `ts` value of that cycle.
- FILL:
  - Every `enable` writes `x` at wptr, then wptr increments modulo 2^ADDR_W. `fill_cnt` increments, saturating at PRETRIG.
  - Go to ARMED once `fill_cnt` = PRETRIG.
  - A trigger in FILL is rejected (`trig_missed`+1), including on the cycle `fill_cnt` reaches PRETRIG.
- ARMED:
  - Writes continue.
  - `enable`&&`trigger` accepts the trigger:
    - latch `ts_trig` = current `ts`;
    - latch record start = wptr − PRETRIG (modulo);
    - write the trigger sample;
    - set `post_cnt` = RECORD_LEN − PRETRIG − 1;
    - go to CAPTURE.
  - If RECORD_LEN − PRETRIG − 1 = 0, go directly to READOUT.
- CAPTURE:
  - Each `enable` writes one sample and decrements `post_cnt`.
  - The write that takes `post_cnt` to 0 goes to READOUT.
  - `enable` low pauses capture.
  - Triggers are rejected and counted.
- READOUT:
  - No buffer writes. Incoming samples are discarded; `ts` still counts.
  - Word sequence: `ts_trig[31:16]`, `ts_trig[15:0]`, then RECORD_LEN samples in time order from record start. `dout_last` is asserted with the final sample.
  - After the last word transfers, clear `fill_cnt` and go to FILL. Pretrigger must be refilled with fresh samples.
  - Triggers are rejected and counted.
- Handshake:
  - A transfer occurs when `dout_valid`&&`dout_ready`.
  - Once asserted, `dout_valid`, `dout` and `dout_last` stay stable until the transfer.
  - `dout_valid` never depends combinationally on `dout_ready`.
- `trig_missed` saturates at 0xFFFF and clears only on reset.

## Timing
- Reset (`reset_n`=0 at a clock edge) takes effect on that edge:
  - state FILL, `ts`=0, wptr=0, `fill_cnt`=0, `trig_missed`=0;
  - `dout_valid`=0, `dout_last`=0, `dout`=0, `busy`=0.
- Reset mid-record or mid-readout aborts the record. No partial `dout_last` is emitted.
- The buffer is 1-cycle-latency synchronous RAM. Readout prefetches so that:
  - the first header word is valid ≤2 cycles after entering READOUT;
  - with `dout_ready` held high, one word transfers every cycle with no bubbles.
- `busy` rises the cycle after an accepted trigger. It falls the cycle after the `dout_last` transfer.
- Minimum dead time per record: (RECORD_LEN − PRETRIG) enabled samples, plus RECORD_LEN+2 transfers, plus PRETRIG enabled samples.
- Wraparound: record start and the read pointer wrap modulo 2^ADDR_W. With RECORD_LEN = 2^ADDR_W, the oldest pretrigger word is still intact at readout start.

## Test plan
Benches use PRETRIG=8, RECORD_LEN=32, ADDR_W=5 unless stated.

1. Ramp `x`=ts[15:0], `enable`=1, trigger at ts=100, `dout_ready`=1 -> header 0x0000, 0x0064, then samples 92..123 consecutively, `dout_last` only on 123, `trig_missed`=0.
2. Trigger at ts=5 (fill incomplete), then at ts=8 (`fill_cnt` reaching 8 that cycle), then at ts=9 -> first two rejected (`trig_missed`=2); ts=9 accepted, record 1..32.
3. During CAPTURE and READOUT, pulse trigger 3 times -> `trig_missed`+3, record unchanged, next accept only after 8 new samples in FILL.
4. `dout_ready` random 30% duty, `enable` toggling every other cycle during CAPTURE -> record content identical to scenario 1, outputs stable while `dout_ready`=0.
5. Place the trigger so the record start is at wptr=28, with RECORD_LEN=32 -> correct wrap, samples in strict time order.
6. Assert `reset_n`=0 for one cycle mid-readout at word 10 -> `dout_valid`=0 next cycle, `trig_missed`=0, `ts` restarts from 0, a new record is produced normally afterward.
